avalon_mm_stream_reader: RTL and testbench

Avalon-MM read master that drains a block of words from the on-chip memory slave and delivers them as a ready/valid stream, e.g. to the VGA pixel path. Software or a control FSM supplies a base word address and a word count and pulses start. The block issues pipelined reads, buffers the returned data in a credit-controlled FIFO, and pulses done once the last word has been consumed downstream.

---
 rtl/avalon_reader_pkg.sv | 13 +
 rtl/stream_reader_fifo.sv | 57 +++++
 rtl/avalon_mm_stream_reader.sv | 153 +++++++++++++++
 tb/tb_avalon_mm_stream_reader.sv | 367 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/avalon_reader_pkg.sv
// Shared types, default widths and sizing helper for the Avalon-MM stream reader.
package avalon_reader_pkg;

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam int DEF_ADDR_W = 17;
  localparam int DEF_DATA_W = 32;

  function automatic int fifo_ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/stream_reader_fifo.sv
// Synchronous return-data FIFO; registered head, so a push is visible one cycle later.
module stream_reader_fifo
  import avalon_reader_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     empty,
  output logic                     full,
  output logic [fifo_ptr_w(DEPTH):0] used
);

  localparam int PTR_W = fifo_ptr_w(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W:0]    r_used;
  logic              w_push;
  logic              w_pop;

  assign w_pop  = pop && !empty;
  // A pop in the same cycle frees the slot a push into a full FIFO needs.
  assign w_push = push && (!full || w_pop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_used   <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_used <= r_used + (PTR_W+1)'(1);
        2'b01:   r_used <= r_used - (PTR_W+1)'(1);
        default: r_used <= r_used;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign empty = (r_used == '0);
  assign full  = (r_used == (PTR_W+1)'(DEPTH));
  assign used  = r_used;

endmodule

// File: rtl/avalon_mm_stream_reader.sv
// Avalon-MM pipelined read master draining a word block into a ready/valid stream.
//   state | meaning
//   IDLE  | waiting for start
//   READ  | issuing reads under FIFO credit
//   DRAIN | all reads issued, waiting for the stream to consume the block
module avalon_mm_stream_reader
  import avalon_reader_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  input  logic [ADDR_W:0]     word_count,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic                avm_read,
  output logic [DATA_W/8-1:0] avm_byteenable,
  input  logic                avm_waitrequest,
  input  logic [DATA_W-1:0]   avm_readdata,
  input  logic                avm_readdatavalid,
  output logic [DATA_W-1:0]   src_data,
  output logic                src_valid,
  input  logic                src_ready
);

  localparam int CW = fifo_ptr_w(FIFO_DEPTH) + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W:0]   r_count;
  logic [ADDR_W:0]   r_issued;
  logic [ADDR_W:0]   r_consumed;
  logic [CW-1:0]     r_pending;
  logic [CW-1:0]     w_used;
  logic              r_done;
  logic              w_done_nxt;
  logic              w_load;
  logic              w_accept;
  logic              w_ret;
  logic              w_pop;
  logic              w_empty;
  logic              w_full;
  logic              w_last_accept;
  logic              w_last_pop;

  // Credits cover both buffered words and reads still in flight.
  assign avm_read = (r_state == READ) && (r_issued < r_count) &&
                    (({1'b0, w_used} + {1'b0, r_pending}) < CREDITS);

  assign w_accept      = avm_read && !avm_waitrequest;
  assign w_ret         = avm_readdatavalid && (r_pending != '0);
  assign w_pop         = src_valid && src_ready;
  assign w_last_accept = w_accept && ((r_issued + (ADDR_W+1)'(1)) == r_count);
  assign w_last_pop    = w_pop && ((r_consumed + (ADDR_W+1)'(1)) == r_count);

  always_comb begin
    w_state_nxt = r_state;
    w_done_nxt  = 1'b0;
    w_load      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (start) begin
          if (word_count != '0) begin
            w_load      = 1'b1;
            w_state_nxt = READ;
          end else begin
            w_done_nxt = 1'b1;
          end
        end
      end
      READ: begin
        if (w_last_accept) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        if (w_last_pop) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_done  <= w_done_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_addr     <= '0;
      r_count    <= '0;
      r_issued   <= '0;
      r_consumed <= '0;
      r_pending  <= '0;
    end else begin
      if (w_load) begin
        r_addr     <= base_addr;
        r_count    <= word_count;
        r_issued   <= '0;
        r_consumed <= '0;
      end else begin
        if (w_accept) begin
          r_addr   <= r_addr + ADDR_W'(1);
          r_issued <= r_issued + (ADDR_W+1)'(1);
        end
        if (w_pop) r_consumed <= r_consumed + (ADDR_W+1)'(1);
      end
      case ({w_accept, w_ret})
        2'b10:   r_pending <= r_pending + CW'(1);
        2'b01:   r_pending <= r_pending - CW'(1);
        default: r_pending <= r_pending;
      endcase
    end
  end

  stream_reader_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (w_ret),
    .pop     (w_pop),
    .din     (avm_readdata),
    .dout    (src_data),
    .empty   (w_empty),
    .full    (w_full),
    .used    (w_used)
  );

  assign src_valid      = !w_empty;
  assign busy           = (r_state != IDLE);
  assign done           = r_done;
  assign avm_address    = r_addr;
  assign avm_byteenable = '1;

  a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
    !(w_ret && w_full && !w_pop));

endmodule

// File: tb/tb_avalon_mm_stream_reader.sv
// Scoreboard bench: memory slave model with stall/latency control, stream checker.
module tb_avalon_mm_stream_reader;

  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 16;

  logic                clk = 1'b0;
  logic                reset_n = 1'b0;
  logic                start = 1'b0;
  logic [ADDR_W-1:0]   base_addr = '0;
  logic [ADDR_W:0]     word_count = '0;
  logic                busy;
  logic                done;
  logic [ADDR_W-1:0]   avm_address;
  logic                avm_read;
  logic [DATA_W/8-1:0] avm_byteenable;
  logic                avm_waitrequest = 1'b0;
  logic [DATA_W-1:0]   avm_readdata = '0;
  logic                avm_readdatavalid = 1'b0;
  logic [DATA_W-1:0]   src_data;
  logic                src_valid;
  logic                src_ready = 1'b1;

  always #5 clk = ~clk;

  avalon_mm_stream_reader #(
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .start             (start),
    .base_addr         (base_addr),
    .word_count        (word_count),
    .busy              (busy),
    .done              (done),
    .avm_address       (avm_address),
    .avm_read          (avm_read),
    .avm_byteenable    (avm_byteenable),
    .avm_waitrequest   (avm_waitrequest),
    .avm_readdata      (avm_readdata),
    .avm_readdatavalid (avm_readdatavalid),
    .src_data          (src_data),
    .src_valid         (src_valid),
    .src_ready         (src_ready)
  );

  typedef struct {
    int                due;
    logic [DATA_W-1:0] data;
  } ret_t;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [ADDR_W-1:0] exp_addr_q [$];
  logic [DATA_W-1:0] exp_data_q [$];
  ret_t              ret_q [$];

  int   lat = 1;
  int   n_acc = 0, n_beats = 0, n_done = 0, max_out = 0;
  int   start_cyc = 0, first_rd_cyc = -1, first_beat_cyc = -1, last_beat_cyc = -1, done_cyc = -1;
  logic busy_at_done = 1'b0;
  int   stall_at = -1, stall_left = 0, stall_seen = 0;
  logic ready_val = 1'b1;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA500_0000 + 32'(a);
  endfunction

  // One clock: slave response, stream scoreboard, done tracking; all sampled at negedge.
  task automatic step();
    logic [ADDR_W-1:0] e_addr;
    logic [DATA_W-1:0] e_data;
    @(negedge clk);
    cyc++;
    if (ret_q.size() > 0 && ret_q[0].due <= cyc) begin
      avm_readdatavalid = 1'b1;
      avm_readdata      = ret_q[0].data;
      void'(ret_q.pop_front());
    end else begin
      avm_readdatavalid = 1'b0;
      avm_readdata      = 32'hDEAD_BEEF;
    end
    if (stall_left > 0) begin
      avm_waitrequest = 1'b1;
      stall_left--;
    end else if (stall_at >= 0 && n_acc == stall_at && avm_read === 1'b1) begin
      avm_waitrequest = 1'b1;
      stall_left = 2;
      stall_at = -1;
    end else begin
      avm_waitrequest = 1'b0;
    end
    src_ready = ready_val;
    e_addr = (exp_addr_q.size() > 0) ? exp_addr_q[0] : '0;
    if (reset_n && avm_waitrequest) begin
      stall_seen++;
      n_checks++;
      if (avm_read !== 1'b1 || exp_addr_q.size() == 0 || avm_address !== e_addr) begin
        n_fail++;
        $display("FAIL stall_hold: read=%b addr=%h, expected read=1 addr=%h", avm_read, avm_address, e_addr);
      end
    end
    if (reset_n && avm_read === 1'b1 && !avm_waitrequest) begin
      n_checks++;
      if (exp_addr_q.size() == 0 || avm_address !== e_addr) begin
        n_fail++;
        $display("FAIL rd_addr: got %h, expected %h (queue size %0d)", avm_address, e_addr, exp_addr_q.size());
      end
      if (exp_addr_q.size() > 0) void'(exp_addr_q.pop_front());
      ret_q.push_back('{cyc + lat, mem_word(avm_address)});
      if (first_rd_cyc < 0) first_rd_cyc = cyc;
      n_acc++;
    end
    if (n_acc - n_beats > max_out) max_out = n_acc - n_beats;
    if (reset_n && src_valid === 1'b1 && src_ready) begin
      n_beats++;
      if (first_beat_cyc < 0) first_beat_cyc = cyc;
      last_beat_cyc = cyc;
      n_checks++;
      if (exp_data_q.size() == 0) begin
        n_fail++;
        $display("FAIL stream_extra: got beat %h, expected no beat", src_data);
      end else begin
        e_data = exp_data_q.pop_front();
        if (src_data !== e_data) begin
          n_fail++;
          $display("FAIL stream_data: got %h, expected %h", src_data, e_data);
        end
      end
    end
    if (done === 1'b1) begin
      n_done++;
      done_cyc = cyc;
      busy_at_done = busy;
    end
  endtask

  task automatic kick(input logic [ADDR_W-1:0] b, input logic [ADDR_W:0] c);
    start = 1'b1;
    base_addr = b;
    word_count = c;
    start_cyc = cyc;
    n_acc = 0; n_beats = 0; n_done = 0; max_out = 0; stall_seen = 0;
    first_rd_cyc = -1; first_beat_cyc = -1; last_beat_cyc = -1; done_cyc = -1;
    for (int i = 0; i < int'(c); i++) begin
      logic [ADDR_W-1:0] a;
      a = b + ADDR_W'(i);
      exp_addr_q.push_back(a);
      exp_data_q.push_back(mem_word(a));
    end
    step();
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
  endtask

  task automatic run_to_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      step();
      if (done === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    #1;
    n_checks++;
    if ({busy, done, avm_read, src_valid} !== 4'b0000 || avm_address !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: busy=%b done=%b read=%b valid=%b addr=%h, expected all 0",
               busy, done, avm_read, src_valid, avm_address);
    end
    n_checks++;
    if (avm_byteenable !== 4'hF) begin
      n_fail++;
      $display("FAIL byteenable: got %h, expected f", avm_byteenable);
    end
    step(); step();
    reset_n = 1'b1;
    step(); step();
  endtask

  task automatic test_basic();
    bit ok;
    kick(17'h10, 18'd8);
    run_to_done(60, ok);
    n_checks++;
    if (!ok) begin n_fail++; $display("FAIL basic_done: timeout, got no done, expected done"); end
    n_checks++;
    if (n_beats != 8 || n_acc != 8) begin
      n_fail++;
      $display("FAIL basic_count: beats=%0d reads=%0d, expected 8 and 8", n_beats, n_acc);
    end
    n_checks++;
    if (first_rd_cyc - start_cyc != 1) begin
      n_fail++;
      $display("FAIL basic_read_lat: got %0d, expected 1", first_rd_cyc - start_cyc);
    end
    n_checks++;
    if (first_beat_cyc - start_cyc != 3) begin
      n_fail++;
      $display("FAIL basic_first_beat: got cycle %0d, expected 3", first_beat_cyc - start_cyc);
    end
    n_checks++;
    if (last_beat_cyc - first_beat_cyc != 7) begin
      n_fail++;
      $display("FAIL basic_throughput: got span %0d, expected 7", last_beat_cyc - first_beat_cyc);
    end
    n_checks++;
    if (done_cyc - last_beat_cyc != 1 || busy_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_timing: got delay %0d busy=%b, expected 1 and 0", done_cyc - last_beat_cyc, busy_at_done);
    end
    step();
    n_checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_done_pulse: done=%b busy=%b, expected 0 0", done, busy);
    end
  endtask

  task automatic test_count_zero();
    kick(17'h5, 18'd0);
    n_checks++;
    if (n_done != 1 || done_cyc != start_cyc + 1 || busy_at_done !== 1'b0) begin
      n_fail++;
      $display("FAIL zero_done: dones=%0d at %0d busy=%b, expected 1 at %0d busy=0",
               n_done, done_cyc, busy_at_done, start_cyc + 1);
    end
    repeat (5) step();
    n_checks++;
    if (n_acc != 0 || n_beats != 0 || n_done != 1) begin
      n_fail++;
      $display("FAIL zero_quiet: reads=%0d beats=%0d dones=%0d, expected 0 0 1", n_acc, n_beats, n_done);
    end
  endtask

  task automatic test_stall();
    bit ok;
    stall_at = 1;
    kick(17'h20, 18'd4);
    run_to_done(60, ok);
    n_checks++;
    if (!ok || n_beats != 4 || exp_data_q.size() != 0) begin
      n_fail++;
      $display("FAIL stall_beats: done=%0b beats=%0d left=%0d, expected 1 4 0", ok, n_beats, exp_data_q.size());
    end
    n_checks++;
    if (stall_seen != 3) begin
      n_fail++;
      $display("FAIL stall_len: got %0d stalled cycles, expected 3", stall_seen);
    end
    stall_at = -1;
  endtask

  task automatic test_wrap();
    bit ok;
    kick(17'h1FFFE, 18'd4);
    run_to_done(60, ok);
    n_checks++;
    if (!ok || n_acc != 4 || n_beats != 4 || exp_addr_q.size() != 0) begin
      n_fail++;
      $display("FAIL wrap: done=%0b reads=%0d beats=%0d, expected 1 4 4", ok, n_acc, n_beats);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    ready_val = 1'b0;
    kick(17'h40, 18'd40);
    repeat (30) step();
    n_checks++;
    if (max_out != DEPTH || avm_read !== 1'b0 || n_beats != 0) begin
      n_fail++;
      $display("FAIL credit_limit: outstanding=%0d read=%b beats=%0d, expected %0d 0 0",
               max_out, avm_read, n_beats, DEPTH);
    end
    ready_val = 1'b1;
    run_to_done(300, ok);
    n_checks++;
    if (!ok || n_beats != 40 || exp_data_q.size() != 0 || max_out > DEPTH) begin
      n_fail++;
      $display("FAIL credit_drain: done=%0b beats=%0d max=%0d, expected 1 40 <=%0d", ok, n_beats, max_out, DEPTH);
    end
  endtask

  task automatic test_start_busy();
    bit ok;
    kick(17'h100, 18'd6);
    step();
    start = 1'b1;
    base_addr = 17'h200;
    word_count = 18'd3;
    step();
    start = 1'b0;
    base_addr = '0;
    word_count = '0;
    run_to_done(60, ok);
    repeat (6) step();
    n_checks++;
    if (!ok || n_beats != 6 || n_acc != 6 || n_done != 1 || exp_data_q.size() != 0) begin
      n_fail++;
      $display("FAIL start_busy: done=%0b beats=%0d reads=%0d dones=%0d, expected 1 6 6 1",
               ok, n_beats, n_acc, n_done);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int bad;
    lat = 3;
    kick(17'h300, 18'd10);
    for (int i = 0; i < 40 && n_beats < 3; i++) step();
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    n_checks++;
    if ({busy, done, avm_read, src_valid} !== 4'b0000 || avm_address !== '0) begin
      n_fail++;
      $display("FAIL midreset_outputs: busy=%b done=%b read=%b valid=%b addr=%h, expected all 0",
               busy, done, avm_read, src_valid, avm_address);
    end
    exp_addr_q.delete();
    exp_data_q.delete();
    n_done = 0;
    step();
    reset_n = 1'b1;
    bad = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (src_valid !== 1'b0 || done !== 1'b0 || busy !== 1'b0) bad++;
    end
    n_checks++;
    if (bad != 0 || n_done != 0) begin
      n_fail++;
      $display("FAIL midreset_stray: bad cycles=%0d dones=%0d, expected 0 0", bad, n_done);
    end
    lat = 1;
    kick(17'h0, 18'd2);
    run_to_done(40, ok);
    n_checks++;
    if (!ok || n_beats != 2 || exp_data_q.size() != 0) begin
      n_fail++;
      $display("FAIL midreset_restart: done=%0b beats=%0d, expected 1 2", ok, n_beats);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_count_zero();
    test_stall();
    test_wrap();
    test_backpressure();
    test_start_busy();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
